// File: rtl/triangle_setup.sv
// triangle_setup: signed-area cull, bbox clamp and edge-function setup for one triangle at a time.
module triangle_setup #(
  parameter int DATAWIDTH = 12,
  parameter int SCREEN_WIDTH = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int CULL_BACK = 1,
  parameter int EDGE_W = 2*DATAWIDTH+5,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATAWIDTH-1:0] i_v0 [3],
  input  logic [DATAWIDTH-1:0] i_v1 [3],
  input  logic [DATAWIDTH-1:0] i_v2 [3],
  input  logic i_dv,
  output logic o_ready,
  input  logic i_next,
  output logic [XW-1:0] o_bbox_min_x,
  output logic [XW-1:0] o_bbox_max_x,
  output logic [YW-1:0] o_bbox_min_y,
  output logic [YW-1:0] o_bbox_max_y,
  output logic signed [DATAWIDTH:0] o_edge_a [3],
  output logic signed [DATAWIDTH:0] o_edge_b [3],
  output logic signed [EDGE_W-1:0] o_edge_init [3],
  output logic signed [EDGE_W-1:0] o_area2,
  output logic [DATAWIDTH-1:0] o_z [3],
  output logic o_dv,
  output logic [15:0] o_accepted_cnt,
  output logic [15:0] o_culled_cnt
);
  typedef enum logic [2:0] {IDLE, AREA, CULL, EDGE, OUT} state_t;
  localparam logic signed [DATAWIDTH-1:0] XMAX = DATAWIDTH'(SCREEN_WIDTH-1);
  localparam logic signed [DATAWIDTH-1:0] YMAX = DATAWIDTH'(SCREEN_HEIGHT-1);
  state_t state_q, state_d;
  logic phase_q, phase_d;
  logic signed [DATAWIDTH-1:0] vx_q [3], vx_d [3], vy_q [3], vy_d [3];
  logic [DATAWIDTH-1:0] vz_q [3], vz_d [3];
  logic signed [EDGE_W-1:0] prod0_q, prod0_d, prod1_q, prod1_d, area_q, area_d;
  logic signed [DATAWIDTH-1:0] min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
  logic [XW-1:0] bx_lo_q, bx_lo_d, bx_hi_q, bx_hi_d;
  logic [YW-1:0] by_lo_q, by_lo_d, by_hi_q, by_hi_d;
  logic signed [DATAWIDTH:0] edge_a_q [3], edge_a_d [3], edge_b_q [3], edge_b_d [3];
  logic signed [EDGE_W-1:0] edge_init_q [3], edge_init_d [3];
  logic [15:0] acc_cnt_q, acc_cnt_d, cul_cnt_q, cul_cnt_d;
  logic neg, off, cull;
  function automatic logic signed [EDGE_W-1:0] ext(input logic signed [DATAWIDTH-1:0] v);
    return EDGE_W'(v);
  endfunction
  function automatic logic signed [EDGE_W-1:0] edge_fn(input logic signed [EDGE_W-1:0] ax, ay, bx, by, px, py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction
  function automatic logic signed [DATAWIDTH-1:0] min3(input logic signed [DATAWIDTH-1:0] a, b, c);
    return (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction
  function automatic logic signed [DATAWIDTH-1:0] max3(input logic signed [DATAWIDTH-1:0] a, b, c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  assign neg = area_q[EDGE_W-1];
  assign off = max_x_q[DATAWIDTH-1] || (min_x_q > XMAX) || max_y_q[DATAWIDTH-1] || (min_y_q > YMAX);
  assign cull = (area_q == '0) || (neg && CULL_BACK != 0) || off;
  // AREA spends two cycles: products are registered before the subtract.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vx_d = vx_q;
    vy_d = vy_q;
    vz_d = vz_q;
    prod0_d = prod0_q;
    prod1_d = prod1_q;
    area_d = area_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    bx_lo_d = bx_lo_q;
    bx_hi_d = bx_hi_q;
    by_lo_d = by_lo_q;
    by_hi_d = by_hi_q;
    edge_a_d = edge_a_q;
    edge_b_d = edge_b_q;
    edge_init_d = edge_init_q;
    acc_cnt_d = acc_cnt_q;
    cul_cnt_d = cul_cnt_q;
    case (state_q)
      IDLE: if (i_dv) begin
        vx_d = '{i_v0[0], i_v1[0], i_v2[0]};
        vy_d = '{i_v0[1], i_v1[1], i_v2[1]};
        vz_d = '{i_v0[2], i_v1[2], i_v2[2]};
        phase_d = 1'b0;
        state_d = AREA;
      end
      AREA: if (!phase_q) begin
        prod0_d = (ext(vx_q[1]) - ext(vx_q[0])) * (ext(vy_q[2]) - ext(vy_q[0]));
        prod1_d = (ext(vy_q[1]) - ext(vy_q[0])) * (ext(vx_q[2]) - ext(vx_q[0]));
        min_x_d = min3(vx_q[0], vx_q[1], vx_q[2]);
        max_x_d = max3(vx_q[0], vx_q[1], vx_q[2]);
        min_y_d = min3(vy_q[0], vy_q[1], vy_q[2]);
        max_y_d = max3(vy_q[0], vy_q[1], vy_q[2]);
        phase_d = 1'b1;
      end else begin
        area_d = prod0_q - prod1_q;
        phase_d = 1'b0;
        state_d = CULL;
      end
      CULL: if (cull) begin
        cul_cnt_d = cul_cnt_q + 16'd1;
        state_d = IDLE;
      end else begin
        if (neg) begin
          vx_d = '{vx_q[0], vx_q[2], vx_q[1]};
          vy_d = '{vy_q[0], vy_q[2], vy_q[1]};
          vz_d = '{vz_q[0], vz_q[2], vz_q[1]};
          area_d = -area_q;
        end
        bx_lo_d = min_x_q[DATAWIDTH-1] ? '0 : (min_x_q > XMAX) ? XW'(XMAX) : XW'(min_x_q);
        bx_hi_d = max_x_q[DATAWIDTH-1] ? '0 : (max_x_q > XMAX) ? XW'(XMAX) : XW'(max_x_q);
        by_lo_d = min_y_q[DATAWIDTH-1] ? '0 : (min_y_q > YMAX) ? YW'(YMAX) : YW'(min_y_q);
        by_hi_d = max_y_q[DATAWIDTH-1] ? '0 : (max_y_q > YMAX) ? YW'(YMAX) : YW'(max_y_q);
        state_d = EDGE;
      end
      EDGE: begin
        for (int i = 0; i < 3; i++) begin
          edge_a_d[i] = (DATAWIDTH+1)'(vy_q[(i+1)%3]) - (DATAWIDTH+1)'(vy_q[(i+2)%3]);
          edge_b_d[i] = (DATAWIDTH+1)'(vx_q[(i+2)%3]) - (DATAWIDTH+1)'(vx_q[(i+1)%3]);
          edge_init_d[i] = edge_fn(ext(vx_q[(i+1)%3]), ext(vy_q[(i+1)%3]),
                                   ext(vx_q[(i+2)%3]), ext(vy_q[(i+2)%3]),
                                   EDGE_W'(bx_lo_q), EDGE_W'(by_lo_q));
        end
        state_d = OUT;
      end
      OUT: if (i_next) begin
        acc_cnt_d = acc_cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      vx_q <= '{default: '0};
      vy_q <= '{default: '0};
      vz_q <= '{default: '0};
      prod0_q <= '0;
      prod1_q <= '0;
      area_q <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      bx_lo_q <= '0;
      bx_hi_q <= '0;
      by_lo_q <= '0;
      by_hi_q <= '0;
      edge_a_q <= '{default: '0};
      edge_b_q <= '{default: '0};
      edge_init_q <= '{default: '0};
      acc_cnt_q <= '0;
      cul_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      vz_q <= vz_d;
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
      area_q <= area_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      bx_lo_q <= bx_lo_d;
      bx_hi_q <= bx_hi_d;
      by_lo_q <= by_lo_d;
      by_hi_q <= by_hi_d;
      edge_a_q <= edge_a_d;
      edge_b_q <= edge_b_d;
      edge_init_q <= edge_init_d;
      acc_cnt_q <= acc_cnt_d;
      cul_cnt_q <= cul_cnt_d;
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_dv = state_q == OUT;
  assign o_bbox_min_x = bx_lo_q;
  assign o_bbox_max_x = bx_hi_q;
  assign o_bbox_min_y = by_lo_q;
  assign o_bbox_max_y = by_hi_q;
  assign o_edge_a = edge_a_q;
  assign o_edge_b = edge_b_q;
  assign o_edge_init = edge_init_q;
  assign o_area2 = area_q;
  assign o_z = vz_q;
  assign o_accepted_cnt = acc_cnt_q;
  assign o_culled_cnt = cul_cnt_q;
endmodule

// File: tb/tb_triangle_setup.sv
// tb_triangle_setup: directed checks of triangle_setup with back-face culling on and off.
module tb_triangle_setup;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] v0 [3], v1 [3], v2 [3];
  logic dv = 1'b0, nxt = 1'b1;
  logic rdy, odv, rdy_n, odv_n;
  logic [8:0] bx0, bx1, by0, by1, bx0_n, bx1_n, by0_n, by1_n;
  logic signed [12:0] ea [3], eb [3], ea_n [3], eb_n [3];
  logic signed [28:0] ei [3], ei_n [3], area, area_n;
  logic [11:0] z [3], z_n [3];
  logic [15:0] acc, cul, acc_n, cul_n;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  triangle_setup #(.CULL_BACK(1)) dut (
    .clk(clk), .rst(rst), .i_v0(v0), .i_v1(v1), .i_v2(v2), .i_dv(dv), .o_ready(rdy), .i_next(nxt),
    .o_bbox_min_x(bx0), .o_bbox_max_x(bx1), .o_bbox_min_y(by0), .o_bbox_max_y(by1),
    .o_edge_a(ea), .o_edge_b(eb), .o_edge_init(ei), .o_area2(area), .o_z(z), .o_dv(odv),
    .o_accepted_cnt(acc), .o_culled_cnt(cul));
  triangle_setup #(.CULL_BACK(0)) dut_n (
    .clk(clk), .rst(rst), .i_v0(v0), .i_v1(v1), .i_v2(v2), .i_dv(dv), .o_ready(rdy_n), .i_next(nxt),
    .o_bbox_min_x(bx0_n), .o_bbox_max_x(bx1_n), .o_bbox_min_y(by0_n), .o_bbox_max_y(by1_n),
    .o_edge_a(ea_n), .o_edge_b(eb_n), .o_edge_init(ei_n), .o_area2(area_n), .o_z(z_n), .o_dv(odv_n),
    .o_accepted_cnt(acc_n), .o_culled_cnt(cul_n));
  task automatic set_tri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    v0 = '{12'(x0), 12'(y0), 12'(z0)};
    v1 = '{12'(x1), 12'(y1), 12'(z1)};
    v2 = '{12'(x2), 12'(y2), 12'(z2)};
  endtask
  task automatic send(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    @(negedge clk);
    set_tri(x0, y0, z0, x1, y1, z1, x2, y2, z2);
    dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    step(2);
    n_cmp++;
    if ({rdy, odv, acc, cul, area, bx0, bx1, by0, by1} !== {1'b1, 1'b0, 16'd0, 16'd0, 29'd0, 36'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b dv=%b acc=%0d cul=%0d area=%0d expected rdy=1 dv=0 rest 0", rdy, odv, acc, cul, area);
    end
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_basic;
    nxt = 1'b1;
    send(10, 10, 100, 20, 10, 200, 10, 20, 300);
    n_cmp++;
    if (rdy !== 1'b0) begin n_bad++; $display("FAIL basic_ready_low: got %b expected 0", rdy); end
    step(3);
    n_cmp++;
    if (odv !== 1'b0) begin n_bad++; $display("FAIL basic_dv_early: got %b expected 0", odv); end
    step(1);
    n_cmp++;
    if ({odv, area} !== {1'b1, 29'sd100}) begin n_bad++; $display("FAIL basic_area: got dv=%b area=%0d expected dv=1 area=100", odv, area); end
    n_cmp++;
    if ({bx0, bx1, by0, by1} !== {9'd10, 9'd20, 9'd10, 9'd20}) begin n_bad++; $display("FAIL basic_bbox: got %0d %0d %0d %0d expected 10 20 10 20", bx0, bx1, by0, by1); end
    n_cmp++;
    if ({ei[0], ei[1], ei[2]} !== {29'sd100, 29'sd0, 29'sd0}) begin n_bad++; $display("FAIL basic_init: got %0d %0d %0d expected 100 0 0", ei[0], ei[1], ei[2]); end
    n_cmp++;
    if ({ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]} !== {13'(-10), 13'(10), 13'(0), 13'(-10), 13'(0), 13'(10)}) begin
      n_bad++; $display("FAIL basic_ab: got a=%0d %0d %0d b=%0d %0d %0d expected a=-10 10 0 b=-10 0 10", ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]);
    end
    n_cmp++;
    if ({z[0], z[1], z[2]} !== {12'd100, 12'd200, 12'd300}) begin n_bad++; $display("FAIL basic_z: got %0d %0d %0d expected 100 200 300", z[0], z[1], z[2]); end
    step(1);
    n_cmp++;
    if ({odv, rdy, acc} !== {1'b0, 1'b1, 16'd1}) begin n_bad++; $display("FAIL basic_accept: got dv=%b rdy=%b acc=%0d expected 0 1 1", odv, rdy, acc); end
  endtask
  task automatic test_back_face;
    send(10, 10, 100, 10, 20, 300, 20, 10, 200);
    step(2);
    n_cmp++;
    if (rdy !== 1'b0) begin n_bad++; $display("FAIL bf_ready_early: got %b expected 0", rdy); end
    step(1);
    n_cmp++;
    if ({rdy, cul, odv_n} !== {1'b1, 16'd1, 1'b0}) begin n_bad++; $display("FAIL bf_culled: got rdy=%b cul=%0d dv_n=%b expected 1 1 0", rdy, cul, odv_n); end
    step(1);
    n_cmp++;
    if ({odv, odv_n, area_n} !== {1'b0, 1'b1, 29'sd100}) begin n_bad++; $display("FAIL bf_reorder_area: got dv=%b dv_n=%b area_n=%0d expected 0 1 100", odv, odv_n, area_n); end
    n_cmp++;
    if ({z_n[0], z_n[1], z_n[2], ei_n[0], ei_n[1], ei_n[2]} !== {12'd100, 12'd200, 12'd300, 29'sd100, 29'sd0, 29'sd0}) begin
      n_bad++; $display("FAIL bf_reorder_zinit: got z=%0d %0d %0d init=%0d %0d %0d expected z=100 200 300 init=100 0 0", z_n[0], z_n[1], z_n[2], ei_n[0], ei_n[1], ei_n[2]);
    end
    n_cmp++;
    if ({bx0_n, bx1_n, by0_n, by1_n, ea_n[0], eb_n[0]} !== {9'd10, 9'd20, 9'd10, 9'd20, 13'(-10), 13'(-10)}) begin
      n_bad++; $display("FAIL bf_reorder_bbox: got %0d %0d %0d %0d a0=%0d b0=%0d expected 10 20 10 20 -10 -10", bx0_n, bx1_n, by0_n, by1_n, ea_n[0], eb_n[0]);
    end
    step(1);
    n_cmp++;
    if ({acc_n, rdy_n} !== {16'd2, 1'b1}) begin n_bad++; $display("FAIL bf_reorder_acc: got acc_n=%0d rdy_n=%b expected 2 1", acc_n, rdy_n); end
  endtask
  task automatic test_degenerate;
    send(0, 0, 0, 5, 5, 0, 10, 10, 0);
    step(3);
    n_cmp++;
    if ({rdy, odv, cul, area} !== {1'b1, 1'b0, 16'd2, 29'sd0}) begin n_bad++; $display("FAIL degenerate: got rdy=%b dv=%b cul=%0d area=%0d expected 1 0 2 0", rdy, odv, cul, area); end
  endtask
  task automatic test_offscreen;
    send(-50, 0, 0, -10, 0, 0, -30, 20, 0);
    step(3);
    n_cmp++;
    if ({rdy, odv, cul, area} !== {1'b1, 1'b0, 16'd3, 29'sd800}) begin n_bad++; $display("FAIL offscreen: got rdy=%b dv=%b cul=%0d area=%0d expected 1 0 3 800", rdy, odv, cul, area); end
  endtask
  task automatic test_clamp;
    send(-5, -5, 0, 400, 0, 0, 0, 400, 0);
    step(4);
    n_cmp++;
    if ({odv, area, bx0, bx1, by0, by1} !== {1'b1, 29'sd164000, 9'd0, 9'd319, 9'd0, 9'd319}) begin
      n_bad++; $display("FAIL clamp_bbox: got dv=%b area=%0d bbox=%0d %0d %0d %0d expected 1 164000 0 319 0 319", odv, area, bx0, bx1, by0, by1);
    end
    n_cmp++;
    if ({ei[0], ei[1], ei[2]} !== {29'sd160000, 29'sd2000, 29'sd2000}) begin n_bad++; $display("FAIL clamp_init: got %0d %0d %0d expected 160000 2000 2000", ei[0], ei[1], ei[2]); end
    n_cmp++;
    if ({ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]} !== {13'(-400), 13'(405), 13'(-5), 13'(-400), 13'(-5), 13'(405)}) begin
      n_bad++; $display("FAIL clamp_ab: got a=%0d %0d %0d b=%0d %0d %0d expected a=-400 405 -5 b=-400 -5 405", ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]);
    end
    step(1);
    n_cmp++;
    if (acc !== 16'd2) begin n_bad++; $display("FAIL clamp_acc: got %0d expected 2", acc); end
  endtask
  task automatic test_back_pressure;
    nxt = 1'b0;
    send(10, 10, 100, 20, 10, 200, 10, 20, 300);
    step(4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) set_tri(1, 1, 7, 50, 1, 8, 1, 50, 9);
      dv = (i == 5);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({odv, rdy, area, bx0, bx1, by0, by1, ei[0], z[1]} !== {1'b1, 1'b0, 29'sd100, 9'd10, 9'd20, 9'd10, 9'd20, 29'sd100, 12'd200}) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got dv=%b rdy=%b area=%0d init0=%0d z1=%0d expected 1 0 100 100 200", i, odv, rdy, area, ei[0], z[1]);
      end
    end
    @(negedge clk);
    dv = 1'b0;
    nxt = 1'b1;
    set_tri(-5, -5, 0, 400, 0, 0, 0, 400, 0);
    step(1);
    n_cmp++;
    if ({odv, rdy, acc} !== {1'b0, 1'b1, 16'd3}) begin n_bad++; $display("FAIL bp_release: got dv=%b rdy=%b acc=%0d expected 0 1 3", odv, rdy, acc); end
    @(negedge clk) dv = 1'b1;
    step(1);
    dv = 1'b0;
    n_cmp++;
    if (rdy !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept: got rdy=%b expected 0", rdy); end
    step(4);
    n_cmp++;
    if ({odv, area} !== {1'b1, 29'sd164000}) begin n_bad++; $display("FAIL bp_next_tri: got dv=%b area=%0d expected 1 164000", odv, area); end
    step(1);
  endtask
  task automatic test_reset_mid_op;
    nxt = 1'b0;
    send(10, 10, 100, 20, 10, 200, 10, 20, 300);
    step(3);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rdy, odv, acc, cul, area, bx0, bx1, ei[0], ea[0], z[0]} !== {1'b1, 1'b0, 16'd0, 16'd0, 29'd0, 18'd0, 29'd0, 13'd0, 12'd0}) begin
      n_bad++; $display("FAIL rst_edge: got rdy=%b dv=%b acc=%0d cul=%0d area=%0d init0=%0d expected 1 0 0 0 0 0", rdy, odv, acc, cul, area, ei[0]);
    end
    @(negedge clk) rst = 1'b0;
    send(10, 10, 100, 20, 10, 200, 10, 20, 300);
    step(4);
    n_cmp++;
    if (odv !== 1'b1) begin n_bad++; $display("FAIL rst_reach_out: got %b expected 1", odv); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rdy, odv, acc, cul, area, bx0, bx1, ei[0], ea[0], z[0]} !== {1'b1, 1'b0, 16'd0, 16'd0, 29'd0, 18'd0, 29'd0, 13'd0, 12'd0}) begin
      n_bad++; $display("FAIL rst_out: got rdy=%b dv=%b acc=%0d cul=%0d area=%0d init0=%0d expected 1 0 0 0 0 0", rdy, odv, acc, cul, area, ei[0]);
    end
    @(negedge clk) rst = 1'b0;
    nxt = 1'b1;
    send(10, 10, 100, 20, 10, 200, 10, 20, 300);
    step(4);
    n_cmp++;
    if ({odv, area, ei[0]} !== {1'b1, 29'sd100, 29'sd100}) begin n_bad++; $display("FAIL rst_after: got dv=%b area=%0d init0=%0d expected 1 100 100", odv, area, ei[0]); end
    step(1);
    n_cmp++;
    if ({acc, cul} !== {16'd1, 16'd0}) begin n_bad++; $display("FAIL rst_after_cnt: got acc=%0d cul=%0d expected 1 0", acc, cul); end
  endtask
  initial begin
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset;
    test_basic;
    test_back_face;
    test_degenerate;
    test_offscreen;
    test_clamp;
    test_back_pressure;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
